// File: rtl/spmv_update_packer.sv
// Groups 64-bit SpMV updates into per-partition bins and emits each bin as a packed
// multi-update line, either when the bin fills or when a flush drains the partial bins.
module spmv_update_packer #(
    parameter int PAR_SIZE_W = 10,
    parameter int LINE_UPD   = 8,
    parameter int NUM_BINS   = 4,
    localparam int BIN_W     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1,
    localparam int CNT_W     = $clog2(LINE_UPD) + 1,
    localparam int SLOT_W    = (LINE_UPD > 1) ? $clog2(LINE_UPD) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [63:0]             Update_input,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic                    flush,
    output logic [64*LINE_UPD-1:0]  line_out,
    output logic [BIN_W-1:0]        line_bin,
    output logic [CNT_W-1:0]        line_count,
    output logic                    line_valid,
    input  logic                    line_ready,
    output logic                    flush_done,
    output logic [1:0]              dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a line
    // holds line_out/line_bin/line_count stable from line_valid rising until it transfers.
    typedef enum logic [1:0] {ACCUM = 2'd0, EMIT = 2'd1, FLUSH = 2'd2} state_t;

    state_t           state, state_nx;
    logic [BIN_W-1:0] sel, sel_nx;
    logic             flush_pending, flush_pending_nx;
    logic             flush_done_nx;
    logic             clear_bin;
    logic             accept;
    logic             sel_empty;
    logic [BIN_W-1:0] in_bin;
    logic [CNT_W-1:0] cnt  [NUM_BINS];
    logic [63:0]      data [NUM_BINS][LINE_UPD];

    assign in_bin      = Update_input[32+PAR_SIZE_W +: BIN_W];
    assign input_ready = (state == ACCUM) && !rst;
    assign accept      = input_valid && input_ready;
    assign sel_empty   = (cnt[sel] == '0);
    assign dbg_state   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ACCUM;
            sel           <= '0;
            flush_pending <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            sel           <= sel_nx;
            flush_pending <= flush_pending_nx;
            flush_done    <= flush_done_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        sel_nx           = sel;
        flush_pending_nx = flush_pending;
        flush_done_nx    = 1'b0;
        line_valid       = 1'b0;
        clear_bin        = 1'b0;
        case (state)
            ACCUM: begin
                if (flush) flush_pending_nx = 1'b1;
                // A filling update wins over a flush so the full line goes out first.
                if (accept && cnt[in_bin] == CNT_W'(LINE_UPD - 1)) begin
                    state_nx = EMIT;
                    sel_nx   = in_bin;
                end else if (flush_pending || flush) begin
                    state_nx = FLUSH;
                    sel_nx   = '0;
                end
            end
            EMIT: begin
                line_valid = 1'b1;
                if (flush) flush_pending_nx = 1'b1;
                if (line_ready) begin
                    clear_bin = 1'b1;
                    if (flush_pending || flush) begin
                        state_nx = FLUSH;
                        sel_nx   = '0;
                    end else begin
                        state_nx = ACCUM;
                    end
                end
            end
            FLUSH: begin
                line_valid = !sel_empty;
                clear_bin  = !sel_empty && line_ready;
                if (sel_empty || line_ready) begin
                    if (sel == BIN_W'(NUM_BINS - 1)) begin
                        state_nx         = ACCUM;
                        flush_pending_nx = 1'b0;
                        flush_done_nx    = 1'b1;
                    end else begin
                        sel_nx = sel + BIN_W'(1);
                    end
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BINS; b++) cnt[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BINS; b++) begin
                if (clear_bin && sel == BIN_W'(b))
                    cnt[b] <= '0;
                else if (accept && in_bin == BIN_W'(b))
                    cnt[b] <= cnt[b] + CNT_W'(1);
            end
        end
    end

    // Slot contents need no reset: the count masks anything stale on line_out.
    always_ff @(posedge clk) begin
        if (accept) data[in_bin][cnt[in_bin][SLOT_W-1:0]] <= Update_input;
    end

    always_comb begin
        line_out   = '0;
        line_bin   = '0;
        line_count = '0;
        if (line_valid) begin
            line_bin   = sel;
            line_count = cnt[sel];
            for (int k = 0; k < LINE_UPD; k++)
                if (CNT_W'(k) < cnt[sel]) line_out[64*k +: 64] = data[sel][k];
        end
    end

endmodule

// File: tb/tb_spmv_update_packer.sv
// Directed bench for spmv_update_packer: a per-bin queue model predicts every line and
// flush_done, and literal checks pin the model on the key scenarios.
module tb_spmv_update_packer;

    localparam int PAR_SIZE_W = 10;
    localparam int LINE_UPD   = 8;
    localparam int NUM_BINS   = 4;
    localparam int BIN_W      = 2;
    localparam int CNT_W      = 4;
    localparam int LW         = 64 * LINE_UPD;
    localparam int W          = BIN_W + CNT_W + LW;

    logic             clk, rst;
    logic [63:0]      Update_input;
    logic             input_valid, input_ready, flush;
    logic [LW-1:0]    line_out;
    logic [BIN_W-1:0] line_bin;
    logic [CNT_W-1:0] line_count;
    logic             line_valid, line_ready, flush_done;
    logic [1:0]       dbg_state;

    spmv_update_packer #(.PAR_SIZE_W(PAR_SIZE_W), .LINE_UPD(LINE_UPD), .NUM_BINS(NUM_BINS)) dut (
        .clk(clk), .rst(rst), .Update_input(Update_input), .input_valid(input_valid),
        .input_ready(input_ready), .flush(flush), .line_out(line_out), .line_bin(line_bin),
        .line_count(line_count), .line_valid(line_valid), .line_ready(line_ready),
        .flush_done(flush_done), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    logic [63:0]  mbin [NUM_BINS][$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_lines[$];
    logic [W-1:0] cur, prev_line;
    int           exp_done = 0;
    int           done_pulses = 0;
    bit           flushing = 0;
    bit           hold_prev = 0;

    function automatic int bin_of(input logic [63:0] u);
        return int'((u[63:32] >> PAR_SIZE_W) % NUM_BINS);
    endfunction

    task automatic close_bin(input int b);
        logic [LW-1:0] d;
        d = '0;
        for (int k = 0; k < mbin[b].size(); k++) d[64*k +: 64] = mbin[b][k];
        exp_q.push_back({BIN_W'(b), CNT_W'(mbin[b].size()), d});
        mbin[b].delete();
    endtask

    // Samples 2 time units after each falling edge: inputs are settled and the values
    // seen are exactly those the next rising edge will act on.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cur = {line_bin, line_count, line_out};
            if (rst) begin
                check("rst_input_ready", input_ready, 1'b0);
                check("rst_line_valid", line_valid, 1'b0);
                check("rst_line_fields", cur, '0);
                check("rst_flush_done", flush_done, 1'b0);
                for (int b = 0; b < NUM_BINS; b++) mbin[b].delete();
                exp_q.delete();
                exp_done  = 0;
                flushing  = 0;
                hold_prev = 0;
            end else begin
                if (line_valid) begin
                    if (hold_prev) check("line_held_stable", cur, prev_line);
                    check("ready_low_while_line", input_ready, 1'b0);
                    if (line_ready) begin
                        got_lines.push_back(cur);
                        if (exp_q.size() == 0) check("unexpected_line", line_valid, 1'b0);
                        else check("line", cur, exp_q.pop_front());
                    end
                end
                hold_prev = line_valid && !line_ready;
                prev_line = cur;
                if (flush_done) begin
                    done_pulses++;
                    if (exp_done == 0) begin
                        check("unexpected_flush_done", flush_done, 1'b0);
                    end else begin
                        check("lines_drained_before_done", exp_q.size(), 0);
                        exp_done--;
                        flushing = 0;
                    end
                end
                if (input_valid && input_ready) begin
                    mbin[bin_of(Update_input)].push_back(Update_input);
                    if (mbin[bin_of(Update_input)].size() == LINE_UPD) close_bin(bin_of(Update_input));
                end
                if (flush && !flushing) begin
                    for (int b = 0; b < NUM_BINS; b++) if (mbin[b].size() > 0) close_bin(b);
                    exp_done++;
                    flushing = 1;
                end
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send(input logic [31:0] dst, input logic [31:0] val);
        int n;
        Update_input = {dst, val};
        input_valid  = 1'b1;
        n = 0;
        while (!input_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", input_ready, 1'b1);
        @(negedge clk);
        input_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 100 && done_pulses == d0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("flush_done_pulses", done_pulses, d0 + 1);
    endtask

    // ---------------- directed tests ----------------
    logic [W-1:0] ln, ln1, ln2;
    int d0, fcyc, edges, low;
    bit seen;

    initial begin
        rst = 1'b1; input_valid = 1'b0; Update_input = '0; flush = 1'b0; line_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", dbg_state, 2'd0);
        rst = 1'b0;
        @(negedge clk);

        // Empty flush right after reset; flush held 2 cycles, the second is ignored.
        d0 = done_pulses; fcyc = 0; edges = 0; seen = 0;
        flush = 1'b1;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 2) flush = 1'b0;
            #3;
            if (dbg_state == 2'd2) fcyc++;
            if (flush_done) begin seen = 1; edges = i; end
        end
        flush = 1'b0;
        @(negedge clk);
        check("empty_flush_cycles", fcyc, NUM_BINS);
        check("empty_flush_done_edge", edges - 1, 4);
        repeat (5) @(negedge clk);
        check("empty_flush_one_pulse", done_pulses, d0 + 1);
        check("empty_flush_no_line", got_lines.size(), 0);

        // Full line to bin 1 with line_ready high.
        got_lines.delete();
        for (int i = 0; i < 8; i++) send(32'h400 + i, 32'(i + 1));
        low = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (input_ready) break;
            low++;
            @(negedge clk);
        end
        @(negedge clk);
        check("full_ready_low_cycles", low, 1);
        check("full_line_count_of_lines", got_lines.size(), 1);
        ln = (got_lines.size() > 0) ? got_lines[0] : '0;
        check("full_bin", ln[W-1 -: BIN_W], 2'd1);
        check("full_count", ln[LW +: CNT_W], 4'd8);
        check("full_slot0", ln[0 +: 64], 64'h0000040000000001);
        check("full_slot7", ln[448 +: 64], 64'h0000040700000008);

        // Same line under 5 cycles of backpressure.
        got_lines.delete();
        line_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h400 + i, 32'(i + 1));
        for (int i = 0; i < 5; i++) begin
            #3;
            check("bp_line_valid", line_valid, 1'b1);
            check("bp_input_ready", input_ready, 1'b0);
            @(negedge clk);
        end
        line_ready = 1'b1;
        @(negedge clk);
        #3;
        check("bp_lines", got_lines.size(), 1);
        ln = (got_lines.size() > 0) ? got_lines[0] : '0;
        check("bp_count", ln[LW +: CNT_W], 4'd8);
        check("bp_slot3", ln[192 +: 64], 64'h0000040300000004);
        @(negedge clk);

        // Partial flush: 3 updates in bin 0, 1 in bin 3.
        got_lines.delete();
        d0 = done_pulses;
        send(32'h001, 32'hA); send(32'h002, 32'hB); send(32'h003, 32'hC); send(32'hC05, 32'hD);
        pulse_flush();
        wait_done(d0);
        check("partial_lines", got_lines.size(), 2);
        ln  = (got_lines.size() > 0) ? got_lines[0] : '0;
        ln1 = (got_lines.size() > 1) ? got_lines[1] : '0;
        check("partial0_bin", ln[W-1 -: BIN_W], 2'd0);
        check("partial0_count", ln[LW +: CNT_W], 4'd3);
        check("partial0_slot0", ln[0 +: 64], 64'h000000010000000A);
        check("partial0_unused_zero", ln[LW-1:192], '0);
        check("partial1_bin", ln1[W-1 -: BIN_W], 2'd3);
        check("partial1_count", ln1[LW +: CNT_W], 4'd1);
        check("partial1_slot0", ln1[0 +: 64], 64'h00000C050000000D);
        check("partial1_unused_zero", ln1[LW-1:64], '0);

        // 8th bin-2 update coincides with flush; bins 1 and 3 hold partials.
        got_lines.delete();
        d0 = done_pulses;
        send(32'h401, 32'h1); send(32'h402, 32'h2); send(32'hC01, 32'h3);
        for (int i = 0; i < 7; i++) send(32'h800 + i, 32'h20 + i);
        flush = 1'b1;
        send(32'h807, 32'h27);
        flush = 1'b0;
        wait_done(d0);
        check("simul_lines", got_lines.size(), 3);
        ln  = (got_lines.size() > 0) ? got_lines[0] : '0;
        ln1 = (got_lines.size() > 1) ? got_lines[1] : '0;
        ln2 = (got_lines.size() > 2) ? got_lines[2] : '0;
        check("simul0_bin_count", ln[W-1 -: BIN_W+CNT_W], {2'd2, 4'd8});
        check("simul0_slot7", ln[448 +: 64], 64'h0000080700000027);
        check("simul1_bin_count", ln1[W-1 -: BIN_W+CNT_W], {2'd1, 4'd2});
        check("simul2_bin_count", ln2[W-1 -: BIN_W+CNT_W], {2'd3, 4'd1});

        // Reset while FLUSH presents a stalled line.
        send(32'h010, 32'h1); send(32'h810, 32'h2); send(32'h811, 32'h3);
        line_ready = 1'b0;
        pulse_flush();
        for (int i = 0; i < 20 && !line_valid; i++) @(negedge clk);
        check("midflush_presenting", line_valid, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_line_valid", line_valid, 1'b0);
        check("async_rst_line_out", line_out, '0);
        check("async_rst_input_ready", input_ready, 1'b0);
        check("async_rst_state", dbg_state, 2'd0);
        d0 = done_pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        line_ready = 1'b1;
        got_lines.delete();
        @(negedge clk);
        check("post_rst_no_done", done_pulses, d0);
        pulse_flush();
        wait_done(d0);
        check("post_rst_no_lines", got_lines.size(), 0);

        repeat (3) @(negedge clk);
        check("final_exp_lines_empty", exp_q.size(), 0);
        check("final_done_outstanding", exp_done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
